// File: rtl/exu_branch_stage.sv
// exu_branch_stage: EX->MEM pipeline register with conditional-branch resolution.
// Holds one ALU result behind a valid/ready handshake and raises a one-cycle
// redirect to fetch when an accepted branch is taken.
// Optional build macro EXU_BRANCH_STAT_EN adds the br_cnt / br_taken_cnt counters.
module exu_branch_stage #(
   parameter int unsigned DATA_LEN = 32,
   parameter int unsigned REG_ADDR = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DATA_LEN-1:0] alu_res,
   input  logic                alu_eq,
   input  logic                alu_neq,
   input  logic                alu_lt,
   input  logic                alu_ge,
   input  logic                alu_ltu,
   input  logic                alu_geu,
   input  logic                is_branch,
   input  logic [2:0]          br_funct3,
   input  logic [DATA_LEN-1:0] br_target,
   input  logic [REG_ADDR-1:0] rd,
   input  logic                rd_wen,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [DATA_LEN-1:0] out_res,
   output logic [REG_ADDR-1:0] out_rd,
   output logic                out_rd_wen,
   output logic                redirect_valid,
   output logic [DATA_LEN-1:0] redirect_pc
`ifdef EXU_BRANCH_STAT_EN
   ,
   output logic [31:0]         br_cnt,
   output logic [31:0]         br_taken_cnt
`endif
);

   localparam int unsigned CNT_W = 32;

   logic                out_valid_q,      out_valid_d;
   logic [DATA_LEN-1:0] out_res_q,        out_res_d;
   logic [REG_ADDR-1:0] out_rd_q,         out_rd_d;
   logic                out_rd_wen_q,     out_rd_wen_d;
   logic                redirect_valid_q, redirect_valid_d;
   logic [DATA_LEN-1:0] redirect_pc_q,    redirect_pc_d;

   logic cond_met_c;
   logic br_taken_c;
   logic accept_c;

   // Branch condition selected by funct3; the two reserved encodings never take
   always_comb begin
      cond_met_c = 1'b0;
      case (br_funct3)
         3'b000:  cond_met_c = alu_eq;
         3'b001:  cond_met_c = alu_neq;
         3'b100:  cond_met_c = alu_lt;
         3'b101:  cond_met_c = alu_ge;
         3'b110:  cond_met_c = alu_ltu;
         3'b111:  cond_met_c = alu_geu;
         default: cond_met_c = 1'b0;
      endcase
   end

   // Stage is free when empty or when the held entry leaves this cycle
   assign in_ready   = ~out_valid_q | out_ready;
   assign accept_c   = in_valid & in_ready & ~flush;
   assign br_taken_c = is_branch & cond_met_c;

   // Next-state for the valid bit, payload and redirect
   always_comb begin
      out_valid_d      = out_valid_q;
      out_res_d        = out_res_q;
      out_rd_d         = out_rd_q;
      out_rd_wen_d     = out_rd_wen_q;
      redirect_pc_d    = redirect_pc_q;
      redirect_valid_d = accept_c & br_taken_c;

      if (flush) begin
         out_valid_d = 1'b0;
      end else if (accept_c) begin
         out_valid_d = 1'b1;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept_c) begin
         out_res_d    = alu_res;
         out_rd_d     = rd;
         out_rd_wen_d = rd_wen & ~is_branch;
      end

      if (accept_c && br_taken_c) begin
         redirect_pc_d = br_target;
      end
   end

   // Pipeline registers with synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q      <= 1'b0;
         out_res_q        <= '0;
         out_rd_q         <= '0;
         out_rd_wen_q     <= 1'b0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
      end else begin
         out_valid_q      <= out_valid_d;
         out_res_q        <= out_res_d;
         out_rd_q         <= out_rd_d;
         out_rd_wen_q     <= out_rd_wen_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign out_res        = out_res_q;
   assign out_rd         = out_rd_q;
   assign out_rd_wen     = out_rd_wen_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;

`ifdef EXU_BRANCH_STAT_EN
   logic [CNT_W-1:0] br_cnt_q,       br_cnt_d;
   logic [CNT_W-1:0] br_taken_cnt_q, br_taken_cnt_d;

   // Accepted-branch statistics; flushed entries are never accepted so never counted
   always_comb begin
      br_cnt_d       = br_cnt_q;
      br_taken_cnt_d = br_taken_cnt_q;
      if (accept_c && is_branch) begin
         br_cnt_d = br_cnt_q + CNT_W'(1);
      end
      if (accept_c && br_taken_c) begin
         br_taken_cnt_d = br_taken_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers, wrap naturally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_cnt_q       <= '0;
         br_taken_cnt_q <= '0;
      end else begin
         br_cnt_q       <= br_cnt_d;
         br_taken_cnt_q <= br_taken_cnt_d;
      end
   end

   assign br_cnt       = br_cnt_q;
   assign br_taken_cnt = br_taken_cnt_q;
`endif

endmodule

// File: tb/tb_exu_branch_stage.sv
// Testbench for exu_branch_stage: scoreboard of expected MEM-side entries plus a
// cycle-level reference of valid/redirect/counter state, driven by directed and random traffic.
module tb_exu_branch_stage;

   localparam int unsigned DL = 32;
   localparam int unsigned RA = 5;

   logic          clk = 1'b0;
   logic          rst_n, flush, in_valid, in_ready;
   logic [DL-1:0] alu_res, br_target, out_res, redirect_pc;
   logic          alu_eq, alu_neq, alu_lt, alu_ge, alu_ltu, alu_geu;
   logic          is_branch, rd_wen, out_valid, out_ready, out_rd_wen, redirect_valid;
   logic [2:0]    br_funct3;
   logic [RA-1:0] rd, out_rd;
`ifdef EXU_BRANCH_STAT_EN
   logic [31:0]   br_cnt, br_taken_cnt;
`endif

   always #5 clk = ~clk;

   exu_branch_stage #(.DATA_LEN(DL), .REG_ADDR(RA)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .alu_res(alu_res), .alu_eq(alu_eq), .alu_neq(alu_neq), .alu_lt(alu_lt), .alu_ge(alu_ge),
      .alu_ltu(alu_ltu), .alu_geu(alu_geu), .is_branch(is_branch), .br_funct3(br_funct3),
      .br_target(br_target), .rd(rd), .rd_wen(rd_wen), .out_valid(out_valid),
      .out_ready(out_ready), .out_res(out_res), .out_rd(out_rd), .out_rd_wen(out_rd_wen),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
`ifdef EXU_BRANCH_STAT_EN
      , .br_cnt(br_cnt), .br_taken_cnt(br_taken_cnt)
`endif
   );

   typedef struct {
      logic [DL-1:0] res;
      logic [RA-1:0] rd;
      logic          wen;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;

   // Reference state: cur_* is what the outputs must show this cycle, nxt_* after the next edge
   bit          chk_en = 0, clear_q = 0, exp_in_ready = 1;
   bit          cur_full = 0, nxt_full = 0, cur_redir = 0, nxt_redir = 0, cur_rst = 0, nxt_rst = 1;
   logic [31:0] cur_pc = 0, nxt_pc = 0;
   logic [31:0] cur_bc = 0, nxt_bc = 0, cur_btc = 0, nxt_btc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // fv bit order: 0 eq, 1 neq, 2 lt, 3 ge, 4 ltu, 5 geu
   function automatic bit ref_taken(input logic [2:0] f3, input logic [5:0] fv);
      int sel[8];
      sel = '{0, 1, -1, -1, 2, 3, 4, 5};
      if (sel[f3] < 0) return 1'b0;
      return fv[sel[f3]];
   endfunction

   // One cycle of stimulus; the reference decides what the next edge must produce
   task automatic drive_cycle(input bit rst, input bit fl, input bit vld, input bit ordy,
                              input bit br, input logic [2:0] f3, input logic [5:0] fv,
                              input logic [31:0] res, input logic [31:0] tgt,
                              input logic [4:0] r, input bit w);
      bit acc, tk;
      @(posedge clk);
      #1;
      if (clear_q) exp_q.delete();
      clear_q   = 0;
      cur_full  = nxt_full;
      cur_redir = nxt_redir;
      cur_pc    = nxt_pc;
      cur_rst   = nxt_rst;
      cur_bc    = nxt_bc;
      cur_btc   = nxt_btc;
      chk_en    = 1;

      rst_n = rst; flush = fl; in_valid = vld; out_ready = ordy;
      is_branch = br; br_funct3 = f3;
      {alu_geu, alu_ltu, alu_ge, alu_lt, alu_neq, alu_eq} = fv;
      alu_res = res; br_target = tgt; rd = r; rd_wen = w;

      exp_in_ready = !cur_full || ordy;
      acc = rst && vld && exp_in_ready && !fl;
      tk  = br && ref_taken(f3, fv);
      if (!rst) begin
         nxt_full = 0; nxt_redir = 0; nxt_pc = 0; nxt_rst = 1;
         nxt_bc = 0; nxt_btc = 0; clear_q = 1;
      end else begin
         nxt_rst   = 0;
         nxt_full  = fl ? 1'b0 : acc ? 1'b1 : (cur_full && ordy) ? 1'b0 : cur_full;
         nxt_redir = acc && tk;
         nxt_pc    = (acc && tk) ? tgt : cur_pc;
         nxt_bc    = cur_bc + ((acc && br) ? 32'd1 : 32'd0);
         nxt_btc   = cur_btc + ((acc && tk) ? 32'd1 : 32'd0);
         if (acc) exp_q.push_back('{res: res, rd: r, wen: w && !br});
      end
   endtask

   task automatic idle(input bit ordy);
      drive_cycle(1, 0, 0, ordy, 0, 3'd0, 6'd0, 32'd0, 32'd0, 5'd0, 0);
   endtask

   // Flags derived from real operands so the six flags are mutually consistent
   function automatic logic [5:0] flags_of(input logic [31:0] a, input logic [31:0] b);
      bit eq, lt, ltu;
      eq  = (a == b);
      lt  = ($signed(a) < $signed(b));
      ltu = (a < b);
      return {!ltu, ltu, !lt, lt, !eq, eq};
   endfunction

   task automatic rand_cycle();
      logic [31:0] a, b;
      logic [5:0]  fv;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      fv = ($urandom_range(0, 3) == 0) ? 6'($urandom) : flags_of(a, b);
      drive_cycle($urandom_range(0, 99) != 0, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 1) == 1, 3'($urandom), fv,
                  32'($urandom), 32'($urandom), 5'($urandom), $urandom_range(0, 1) == 1);
   endtask

   // Monitor: compares visible state each cycle and retires entries on handshake or flush
   always @(negedge clk) begin
      if (chk_en) begin
         check("out_valid", 32'(out_valid), 32'(cur_full));
         check("in_ready", 32'(in_ready), 32'(exp_in_ready));
         check("redirect_valid", 32'(redirect_valid), 32'(cur_redir));
         check("redirect_pc", redirect_pc, cur_pc);
         if (cur_rst) begin
            check("reset out_res", out_res, 32'd0);
            check("reset out_rd", 32'(out_rd), 32'd0);
            check("reset out_rd_wen", 32'(out_rd_wen), 32'd0);
         end
`ifdef EXU_BRANCH_STAT_EN
         check("br_cnt", br_cnt, cur_bc);
         check("br_taken_cnt", br_taken_cnt, cur_btc);
`endif
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_entry: got res %h with no entry expected at %0t", out_res, $time);
            end else begin
               check("out_res", out_res, exp_q[0].res);
               check("out_rd", 32'(out_rd), 32'(exp_q[0].rd));
               check("out_rd_wen", 32'(out_rd_wen), 32'(exp_q[0].wen));
               if (out_ready || flush) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      rst_n = 0; flush = 0; in_valid = 1; out_ready = 1; is_branch = 0; br_funct3 = 0;
      {alu_geu, alu_ltu, alu_ge, alu_lt, alu_neq, alu_eq} = 6'd0;
      alu_res = 32'hdead_beef; br_target = 0; rd = 5'd1; rd_wen = 1;

      // reset held two cycles with a valid entry offered
      drive_cycle(0, 0, 1, 1, 0, 3'd0, 6'd0, 32'hdead_beef, 32'd0, 5'd1, 1);
      drive_cycle(0, 0, 1, 1, 0, 3'd0, 6'd0, 32'hdead_beef, 32'd0, 5'd1, 1);
      idle(1);

      // plain ALU result
      drive_cycle(1, 0, 1, 1, 0, 3'd0, 6'd0, 32'h0000_1234, 32'd0, 5'd5, 1);
      idle(1);

      // taken BEQ: one-cycle redirect, rd write suppressed
      drive_cycle(1, 0, 1, 1, 1, 3'b000, 6'b000001, 32'h0000_0001, 32'h8000_0040, 5'd3, 1);
      idle(1); idle(1);

      // untaken BLTU and reserved funct3
      drive_cycle(1, 0, 1, 1, 1, 3'b110, 6'b101111, 32'h0000_0002, 32'h8000_0080, 5'd4, 1);
      drive_cycle(1, 0, 1, 1, 1, 3'b010, 6'b111111, 32'h0000_0003, 32'h8000_00c0, 5'd6, 1);
      idle(1);

      // backpressure: hold three cycles, ignored upstream, then drain+accept together
      drive_cycle(1, 0, 1, 1, 0, 3'd0, 6'd0, 32'h0000_aaaa, 32'd0, 5'd7, 1);
      for (int i = 0; i < 3; i++)
         drive_cycle(1, 0, 1, 0, 1, 3'b000, 6'b000001, 32'h0000_bbbb + 32'(i), 32'h9000_0000, 5'd8, 1);
      drive_cycle(1, 0, 1, 1, 0, 3'd0, 6'd0, 32'h0000_cccc, 32'd0, 5'd9, 1);
      idle(1);

      // flush kills a taken branch; then three branches, two taken
      drive_cycle(1, 1, 1, 1, 1, 3'b000, 6'b000001, 32'h0000_0010, 32'h8000_0100, 5'd0, 0);
      drive_cycle(1, 0, 1, 1, 1, 3'b001, 6'b000010, 32'h0000_0011, 32'h8000_0200, 5'd0, 0);
      drive_cycle(1, 0, 1, 1, 1, 3'b100, 6'b001000, 32'h0000_0012, 32'h8000_0300, 5'd0, 0);
      drive_cycle(1, 0, 1, 1, 1, 3'b111, 6'b100000, 32'h0000_0013, 32'h8000_0400, 5'd0, 0);
      idle(1);

      // flush while an entry is stalled, then reset in mid-stall
      drive_cycle(1, 0, 1, 0, 0, 3'd0, 6'd0, 32'h0000_dddd, 32'd0, 5'd10, 1);
      drive_cycle(1, 1, 1, 0, 0, 3'd0, 6'd0, 32'h0000_eeee, 32'd0, 5'd11, 1);
      drive_cycle(1, 0, 1, 0, 1, 3'b101, 6'b001000, 32'h0000_ffff, 32'h8000_0500, 5'd12, 1);
      drive_cycle(1, 0, 0, 0, 0, 3'd0, 6'd0, 32'd0, 32'd0, 5'd0, 0);
      drive_cycle(0, 0, 1, 0, 0, 3'd0, 6'd0, 32'h0000_1111, 32'd0, 5'd13, 1);
      idle(1); idle(1);

      for (int i = 0; i < 3000; i++) rand_cycle();

      for (int i = 0; i < 4; i++) idle(1);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
